// File: rtl/vga_timing_pkg.sv
// Timing constants for the 1280x1024@60 Hz pixel timing generator.
package vga_timing_pkg;

  localparam int COORD_W = 12;
  localparam int FRAME_W = 16;
  localparam int MAX_TOTAL = 1 << COORD_W;

  localparam int H_ACTIVE_DEF = 1280;
  localparam int H_FP_DEF     = 48;
  localparam int H_SYNC_DEF   = 112;
  localparam int H_BP_DEF     = 248;
  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int V_ACTIVE_DEF = 1024;
  localparam int V_FP_DEF     = 1;
  localparam int V_SYNC_DEF   = 3;
  localparam int V_BP_DEF     = 38;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam bit H_POL_DEF = 1'b1;
  localparam bit V_POL_DEF = 1'b1;

endpackage

// File: rtl/vga_axis_counter.sv
// Modulo-TOTAL counter for one display axis, with wrap-out flag and a
// registered sync-window decode computed from the next count value.
module vga_axis_counter #(
  parameter int W          = 12,
  parameter int TOTAL      = 1688,
  parameter int ACTIVE     = 1280,
  parameter int SYNC_START = 1328,
  parameter int SYNC_LEN   = 112,
  parameter bit POL        = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         act_next,
  output logic         sync
);

  logic [W-1:0] count_next;
  logic         in_window;

  // Next count, terminal-count wrap and decodes of the next position.
  always_comb begin
    wrap       = inc && (count == W'(TOTAL - 1));
    count_next = count;
    if (inc) begin
      count_next = wrap ? '0 : count + 1'b1;
    end
    act_next  = (count_next < W'(ACTIVE));
    in_window = (count_next >= W'(SYNC_START)) &&
                (count_next <= W'(SYNC_START + SYNC_LEN - 1));
  end

  // Count and sync register; sync tracks the count it is shown with.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      sync  <= ~POL;
    end else begin
      count <= count_next;
      sync  <= in_window ? POL : ~POL;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// Pixel timing generator: column/line counters, hsync/vsync, active flag,
// frame_start pulse and frame counter. Build option VGA_SYNC_DELAY_EN
// adds a SYNC_DELAY-stage pipeline on hsync/vsync only.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter bit H_POL      = H_POL_DEF,
  parameter bit V_POL      = V_POL_DEF,
  parameter int SYNC_DELAY = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_en,
  output logic [COORD_W-1:0] column,
  output logic [COORD_W-1:0] line,
  output logic               hsync,
  output logic               vsync,
  output logic               active,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
    $error("vga_sync_gen: H_TOTAL/V_TOTAL exceed coordinate range");
  end
  if (SYNC_DELAY < 1) begin : g_bad_delay
    $error("vga_sync_gen: SYNC_DELAY must be at least 1");
  end

  logic h_wrap, v_wrap;
  logic h_act_next, v_act_next;
  logic hsync_raw, vsync_raw;

  vga_axis_counter #(
    .W(COORD_W), .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE),
    .SYNC_START(H_ACTIVE + H_FP), .SYNC_LEN(H_SYNC), .POL(H_POL)
  ) u_h (
    .clk(clk), .reset(reset), .inc(pix_en),
    .count(column), .wrap(h_wrap), .act_next(h_act_next), .sync(hsync_raw)
  );

  vga_axis_counter #(
    .W(COORD_W), .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE),
    .SYNC_START(V_ACTIVE + V_FP), .SYNC_LEN(V_SYNC), .POL(V_POL)
  ) u_v (
    .clk(clk), .reset(reset), .inc(h_wrap),
    .count(line), .wrap(v_wrap), .act_next(v_act_next), .sync(vsync_raw)
  );

  // Active flag, frame pulse and frame count; v_wrap already implies pix_en.
  always_ff @(posedge clk) begin
    if (reset) begin
      active      <= 1'b1;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      active      <= h_act_next & v_act_next;
      frame_start <= v_wrap;
      if (v_wrap) begin
        frame_count <= frame_count + 1'b1;
      end
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  logic [SYNC_DELAY-1:0] hs_pipe, vs_pipe;

  // Sync delay line, advancing with pixels so it stays in pixel units.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_pipe <= {SYNC_DELAY{~H_POL}};
      vs_pipe <= {SYNC_DELAY{~V_POL}};
    end else if (pix_en) begin
      hs_pipe[0] <= hsync_raw;
      vs_pipe[0] <= vsync_raw;
      for (int i = 1; i < SYNC_DELAY; i++) begin
        hs_pipe[i] <= hs_pipe[i-1];
        vs_pipe[i] <= vs_pipe[i-1];
      end
    end
  end

  assign hsync = hs_pipe[SYNC_DELAY-1];
  assign vsync = vs_pipe[SYNC_DELAY-1];
`else
  assign hsync = hsync_raw;
  assign vsync = vsync_raw;
`endif

endmodule
